// File: rtl/axis_pixels_pack_pkg.sv
// rtl/axis_pixels_pack_pkg.sv - shared widths, FSM states and output vector type for the pixel packer
package axis_pixels_pack_pkg;

  localparam int WORD_WIDTH         = 8;
  localparam int IN_WORDS           = 4;
  localparam int IM_SHIFT_REGS      = 16;
  localparam int BITS_IM_SHIFT      = 4;
  localparam int TUSER_WIDTH_PIXELS = 8;

  localparam int BPV       = IM_SHIFT_REGS / IN_WORDS;
  localparam int BITS_BPV  = $clog2(BPV);
  localparam int IN_WIDTH  = IN_WORDS * WORD_WIDTH;
  localparam int VEC_WIDTH = IM_SHIFT_REGS * WORD_WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // Everything that travels with one output vector, held together in the slot.
  typedef struct packed {
    logic [VEC_WIDTH-1:0]          data;
    logic [BITS_IM_SHIFT-1:0]      shift;
    logic                          ones;
    logic [TUSER_WIDTH_PIXELS-1:0] user;
    logic                          last;
  } vec_t;

endpackage

// File: rtl/axis_pixels_pack_if.sv
// rtl/axis_pixels_pack_if.sv - frame config, input beat and output vector handshake bundles
interface axis_pixels_pack_cfg_if;
  import axis_pixels_pack_pkg::*;

  logic                          cfg_valid;
  logic                          cfg_ready;
  logic [BITS_IM_SHIFT-1:0]      cfg_shift;
  logic                          cfg_ones;
  logic [TUSER_WIDTH_PIXELS-1:0] cfg_user;

  modport master (output cfg_valid, cfg_shift, cfg_ones, cfg_user, input cfg_ready);
  modport slave  (input cfg_valid, cfg_shift, cfg_ones, cfg_user, output cfg_ready);
endinterface

interface axis_pixels_pack_s_if;
  import axis_pixels_pack_pkg::*;

  logic                s_valid;
  logic                s_ready;
  logic [IN_WIDTH-1:0] s_data;
  logic                s_last;

  modport master (output s_valid, s_data, s_last, input s_ready);
  modport slave  (input s_valid, s_data, s_last, output s_ready);
endinterface

interface axis_pixels_pack_m_if;
  import axis_pixels_pack_pkg::*;

  logic                          m_valid;
  logic                          m_ready;
  logic [VEC_WIDTH-1:0]          m_data;
  logic [BITS_IM_SHIFT-1:0]      m_shift;
  logic                          m_ones;
  logic [TUSER_WIDTH_PIXELS-1:0] m_user;
  logic                          m_last;

  modport master (output m_valid, m_data, m_shift, m_ones, m_user, m_last, input m_ready);
  modport slave  (input m_valid, m_data, m_shift, m_ones, m_user, m_last, output m_ready);
endinterface

// File: rtl/axis_pixels_pack_slot.sv
// rtl/axis_pixels_pack_slot.sv - one-entry output register; push and pop may coincide
module axis_pixels_pack_slot
  import axis_pixels_pack_pkg::*;
(
  input  logic aclk,
  input  logic areset,
  input  logic push,
  input  logic pop,
  input  vec_t din,
  output logic valid,
  output vec_t dout,
  output logic slot_free
);

  assign slot_free = ~valid | pop;

  // Caller only pushes when slot_free, so a push always overwrites a drained or draining entry.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      valid <= 1'b0;
      dout  <= '0;
    end else if (push) begin
      valid <= 1'b1;
      dout  <= din;
    end else if (pop) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/axis_pixels_pack.sv
// rtl/axis_pixels_pack.sv - packs IN_WORDS-word pixel beats into IM_SHIFT_REGS-word tagged vectors
module axis_pixels_pack
  import axis_pixels_pack_pkg::*;
(
  input  logic                  aclk,
  input  logic                  areset,
  axis_pixels_pack_cfg_if.slave cfg,
  axis_pixels_pack_s_if.slave   s,
  axis_pixels_pack_m_if.master  m
);

  state_t                        state, state_nxt;
  logic [BITS_BPV-1:0]           count;
  logic [VEC_WIDTH-1:0]          acc, merged;
  logic [BITS_IM_SHIFT-1:0]      shift_q;
  logic                          ones_q;
  logic [TUSER_WIDTH_PIXELS-1:0] user_q;
  logic                          slot_free, slot_valid, last_slot, beat, push;
  vec_t                          push_vec, slot_q;

  assign last_slot = (count == BITS_BPV'(BPV - 1));
  assign beat      = s.s_valid & s.s_ready;

  // Accumulator with the current beat dropped into its word slot.
  always_comb begin
    merged = acc;
    for (int b = 0; b < BPV; b++) begin
      if (count == BITS_BPV'(b)) merged[b*IN_WIDTH +: IN_WIDTH] = s.s_data;
    end
  end

  always_comb begin
    state_nxt     = state;
    cfg.cfg_ready = 1'b0;
    s.s_ready     = 1'b0;
    push          = 1'b0;
    push_vec      = '{data: merged, shift: shift_q, ones: ones_q, user: user_q, last: s.s_last};
    case (state)
      IDLE: begin
        cfg.cfg_ready = 1'b1;
        if (cfg.cfg_valid) state_nxt = FILL;
      end
      FILL: begin
        // Only the vector-completing beat needs the slot, so earlier beats flow under backpressure.
        s.s_ready = slot_free | ~last_slot;
        if (beat) begin
          if (last_slot) push = 1'b1;
          if (s.s_last) begin
            if (last_slot || slot_free) begin
              push      = 1'b1;
              state_nxt = IDLE;
            end else begin
              state_nxt = FLUSH;
            end
          end
        end
      end
      FLUSH: begin
        push_vec.data = acc;
        push_vec.last = 1'b1;
        if (slot_free) begin
          push      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state   <= IDLE;
      count   <= '0;
      acc     <= '0;
      shift_q <= '0;
      ones_q  <= 1'b0;
      user_q  <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && cfg.cfg_valid) begin
        shift_q <= cfg.cfg_shift;
        ones_q  <= cfg.cfg_ones;
        user_q  <= cfg.cfg_user;
      end
      // Clearing on push is what makes short-frame padding zero.
      if (push)      acc <= '0;
      else if (beat) acc <= merged;
      if (beat) count <= (last_slot || s.s_last) ? '0 : count + BITS_BPV'(1);
    end
  end

  axis_pixels_pack_slot u_slot (
    .aclk      (aclk),
    .areset    (areset),
    .push      (push),
    .pop       (m.m_ready),
    .din       (push_vec),
    .valid     (slot_valid),
    .dout      (slot_q),
    .slot_free (slot_free)
  );

  assign m.m_valid = slot_valid;
  assign m.m_data  = slot_q.data;
  assign m.m_shift = slot_q.shift;
  assign m.m_ones  = slot_q.ones;
  assign m.m_user  = slot_q.user;
  assign m.m_last  = slot_q.last;

endmodule

// File: tb/tb_axis_pixels_pack.sv
// tb/tb_axis_pixels_pack.sv - scoreboard bench for the pixel packer
module tb_axis_pixels_pack;
  import axis_pixels_pack_pkg::*;

  logic aclk = 1'b0;
  logic areset;
  always #5 aclk = ~aclk;

  axis_pixels_pack_cfg_if cfg_b ();
  axis_pixels_pack_s_if   s_b ();
  axis_pixels_pack_m_if   m_b ();

  axis_pixels_pack dut (
    .aclk   (aclk),
    .areset (areset),
    .cfg    (cfg_b),
    .s      (s_b),
    .m      (m_b)
  );

  vec_t exp_q[$];
  vec_t mdl;
  int   mdl_w;
  int   n_checks = 0;
  int   n_fail = 0;
  int   lasts_seen = 0;
  int   rmode = 2;
  bit   hold_v = 0;
  vec_t hold_q;

  // Downstream ready: 0 = always ready, 1 = random stalls, 2 = held off.
  always @(posedge aclk) begin
    #1;
    case (rmode)
      0:       m_b.m_ready = 1'b1;
      1:       m_b.m_ready = ($urandom_range(0, 3) != 0);
      default: m_b.m_ready = 1'b0;
    endcase
  end

  always @(negedge aclk) begin : monitor
    vec_t got, exp;
    if (areset) begin
      hold_v = 0;
    end else begin
      got = {m_b.m_data, m_b.m_shift, m_b.m_ones, m_b.m_user, m_b.m_last};
      if (hold_v) begin
        n_checks++;
        if (!m_b.m_valid || got !== hold_q) begin
          n_fail++;
          $display("FAIL hold_stable: valid=%0b got=%h required=%h", m_b.m_valid, got, hold_q);
        end
      end
      hold_v = m_b.m_valid && !m_b.m_ready;
      hold_q = got;
      if (m_b.m_valid && m_b.m_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_vector: got=%h", got);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            n_fail++;
            $display("FAIL vector: got=%h required=%h", got, exp);
          end
          if (got.last) lasts_seen++;
        end
      end
    end
  end

  task automatic do_cfg(input logic [BITS_IM_SHIFT-1:0] sh, input logic on,
                        input logic [TUSER_WIDTH_PIXELS-1:0] us);
    bit ok = 0;
    cfg_b.cfg_shift = sh;
    cfg_b.cfg_ones  = on;
    cfg_b.cfg_user  = us;
    cfg_b.cfg_valid = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge aclk);
      if (cfg_b.cfg_ready) begin ok = 1; break; end
    end
    @(posedge aclk); #1;
    cfg_b.cfg_valid = 1'b0;
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL cfg_timeout: cfg_ready=%0b required=1", cfg_b.cfg_ready);
    end
    mdl = '0;
    mdl.shift = sh; mdl.ones = on; mdl.user = us;
    mdl_w = 0;
  endtask

  task automatic put_beat(input logic [IN_WIDTH-1:0] d, input bit last, input int stall);
    bit ok = 0;
    int idle = (stall > 0) ? $urandom_range(0, stall) : 0;
    for (int i = 0; i < idle; i++) begin @(posedge aclk); #1; end
    s_b.s_data = d; s_b.s_last = last; s_b.s_valid = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge aclk);
      if (s_b.s_ready) begin ok = 1; break; end
    end
    @(posedge aclk); #1;
    s_b.s_valid = 1'b0; s_b.s_last = 1'b0;
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL beat_timeout: s_ready=%0b required=1", s_b.s_ready);
    end
    mdl.data[mdl_w*IN_WIDTH +: IN_WIDTH] = d;
    mdl_w++;
    if (mdl_w == BPV || last) begin
      mdl.last = last;
      exp_q.push_back(mdl);
      mdl.data = '0;
      mdl_w = 0;
    end
  endtask

  function automatic logic [IN_WIDTH-1:0] seq_beat(input int b);
    logic [IN_WIDTH-1:0] d;
    for (int k = 0; k < IN_WORDS; k++) d[k*WORD_WIDTH +: WORD_WIDTH] = WORD_WIDTH'(b*IN_WORDS + k + 1);
    return d;
  endfunction

  task automatic drain(input string name);
    bit ok = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge aclk);
      if (exp_q.size() == 0) begin ok = 1; break; end
    end
    @(posedge aclk); #1;
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL drain_%s: pending=%0d required=0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    areset = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    n_checks += 5;
    if (cfg_b.cfg_ready !== 1'b1) begin n_fail++; $display("FAIL rst_cfg_ready: got=%0b required=1", cfg_b.cfg_ready); end
    if (s_b.s_ready !== 1'b0)     begin n_fail++; $display("FAIL rst_s_ready: got=%0b required=0", s_b.s_ready); end
    if (m_b.m_valid !== 1'b0)     begin n_fail++; $display("FAIL rst_m_valid: got=%0b required=0", m_b.m_valid); end
    if (m_b.m_data !== '0)        begin n_fail++; $display("FAIL rst_m_data: got=%h required=0", m_b.m_data); end
    if ({m_b.m_shift, m_b.m_ones, m_b.m_user, m_b.m_last} !== '0) begin
      n_fail++; $display("FAIL rst_sideband: got=%h required=0", {m_b.m_shift, m_b.m_ones, m_b.m_user, m_b.m_last});
    end
    areset = 1'b0;
    @(posedge aclk); #1;
  endtask

  task automatic test_basic();
    int l0 = lasts_seen;
    rmode = 0;
    do_cfg(4'd2, 1'b0, 8'hA5);
    for (int b = 0; b < 8; b++) put_beat(seq_beat(b), b == 7, 0);
    drain("basic");
    @(negedge aclk);
    n_checks += 2;
    if (lasts_seen - l0 !== 1) begin n_fail++; $display("FAIL basic_lasts: got=%0d required=1", lasts_seen - l0); end
    if (cfg_b.cfg_ready !== 1'b1) begin n_fail++; $display("FAIL basic_idle: cfg_ready=%0b required=1", cfg_b.cfg_ready); end
    @(posedge aclk); #1;
  endtask

  task automatic test_backpressure();
    rmode = 2;
    do_cfg(4'd7, 1'b1, 8'h11);
    for (int b = 0; b < 7; b++) put_beat(seq_beat(b + 20), 1'b0, 0);
    repeat (3) @(negedge aclk);
    n_checks += 2;
    if (s_b.s_ready !== 1'b0) begin n_fail++; $display("FAIL bp_s_ready: got=%0b required=0", s_b.s_ready); end
    if (m_b.m_valid !== 1'b1) begin n_fail++; $display("FAIL bp_m_valid: got=%0b required=1", m_b.m_valid); end
    @(posedge aclk); #1;
    rmode = 0;
    put_beat(seq_beat(27), 1'b1, 0);
    drain("backpressure");
  endtask

  task automatic test_flush();
    rmode = 2;
    do_cfg(4'd9, 1'b0, 8'h5A);
    for (int b = 0; b < 6; b++) put_beat(seq_beat(b + 40), b == 5, 0);
    repeat (4) @(negedge aclk);
    n_checks += 2;
    if (cfg_b.cfg_ready !== 1'b0) begin n_fail++; $display("FAIL flush_cfg_ready: got=%0b required=0", cfg_b.cfg_ready); end
    if (s_b.s_ready !== 1'b0)     begin n_fail++; $display("FAIL flush_s_ready: got=%0b required=0", s_b.s_ready); end
    @(posedge aclk); #1;
    rmode = 0;
    drain("flush");
    @(negedge aclk);
    n_checks++;
    if (cfg_b.cfg_ready !== 1'b1) begin n_fail++; $display("FAIL flush_idle: cfg_ready=%0b required=1", cfg_b.cfg_ready); end
    @(posedge aclk); #1;
  endtask

  task automatic test_cfg_ignore();
    rmode = 0;
    do_cfg(4'd5, 1'b1, 8'h3C);
    put_beat(seq_beat(60), 1'b0, 0);
    put_beat(seq_beat(61), 1'b0, 0);
    cfg_b.cfg_shift = 4'hF; cfg_b.cfg_ones = 1'b0; cfg_b.cfg_user = 8'hEE; cfg_b.cfg_valid = 1'b1;
    @(negedge aclk);
    n_checks++;
    if (cfg_b.cfg_ready !== 1'b0) begin n_fail++; $display("FAIL fill_cfg_ready: got=%0b required=0", cfg_b.cfg_ready); end
    @(posedge aclk); #1;
    cfg_b.cfg_valid = 1'b0;
    for (int b = 2; b < 7; b++) put_beat(seq_beat(60 + b), b == 6, 0);
    do_cfg(4'd1, 1'b0, 8'hC3);
    for (int b = 0; b < 3; b++) put_beat(seq_beat(70 + b), b == 2, 0);
    drain("cfg_ignore");
  endtask

  task automatic test_reset_mid();
    rmode = 2;
    do_cfg(4'd3, 1'b1, 8'h77);
    for (int b = 0; b < 6; b++) put_beat(seq_beat(80 + b), 1'b0, 0);
    #2 areset = 1'b1;
    #1;
    n_checks += 3;
    if (m_b.m_valid !== 1'b0)     begin n_fail++; $display("FAIL mid_rst_m_valid: got=%0b required=0", m_b.m_valid); end
    if (cfg_b.cfg_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rst_cfg_ready: got=%0b required=1", cfg_b.cfg_ready); end
    if (s_b.s_ready !== 1'b0)     begin n_fail++; $display("FAIL mid_rst_s_ready: got=%0b required=0", s_b.s_ready); end
    exp_q.delete();
    @(negedge aclk);
    @(posedge aclk); #1;
    areset = 1'b0;
    rmode = 0;
    do_cfg(4'd4, 1'b0, 8'h42);
    for (int b = 0; b < 3; b++) put_beat(seq_beat(90 + b), b == 2, 0);
    drain("reset_mid");
  endtask

  task automatic test_soak();
    int l0 = lasts_seen;
    rmode = 1;
    for (int f = 0; f < 1000; f++) begin
      int nb = $urandom_range(1, 10);
      do_cfg(BITS_IM_SHIFT'($urandom), 1'($urandom), TUSER_WIDTH_PIXELS'($urandom));
      for (int b = 0; b < nb; b++) put_beat(IN_WIDTH'($urandom), b == nb - 1, 2);
    end
    drain("soak");
    n_checks++;
    if (lasts_seen - l0 !== 1000) begin n_fail++; $display("FAIL soak_lasts: got=%0d required=1000", lasts_seen - l0); end
  endtask

  initial begin
    areset = 1'b1;
    cfg_b.cfg_valid = 1'b0; cfg_b.cfg_shift = '0; cfg_b.cfg_ones = 1'b0; cfg_b.cfg_user = '0;
    s_b.s_valid = 1'b0; s_b.s_data = '0; s_b.s_last = 1'b0;
    m_b.m_ready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_flush();
    test_cfg_ignore();
    test_reset_mid();
    test_soak();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
